ex_hilo_unit: RTL and testbench
===============================

# ex_hilo_unit

EX-stage HI/LO unit: executes MULT/MULTU/DIV/DIVU/MTHI/MTLO and holds the architectural HI and LO registers read by MFHI/MFLO. Takes operands from the ID/EX pipeline register. Multiplies and moves complete in one cycle. Division is a 32-step iterative radix-2 restoring divider that raises `stall` to freeze IF/ID/EX until the result is written.

## Interface
- No parameters; widths fixed at 32-bit MIPS datapath.
- Reset: `resetn`, synchronous, active-low. Clock: `clk`.
- `clk`  in  1  clock
- `resetn`  in  1  synchronous active-low reset
- `ex_valid`  in  1  EX holds a live instruction
- `ex_op`  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- `ex_A`  in  32  GPR[rs]: dividend, multiplicand, or MTHI/MTLO source
- `ex_B`  in  32  GPR[rt]: divisor or multiplier
- `flush`  in  1  exception/cancel of the EX instruction
- `stall`  out  1  pipeline hold request (IF/ID/EX freeze)
- `hi`  out  32  architectural HI register
- `lo`  out  32  architectural LO register

## Operation
- `act = ex_valid & ~flush`.
- `hi`/`lo` are plain registers; reset value is 0.
- MULT/MULTU with `act`: 64-bit signed or unsigned product of A×B. At the clock edge, `{hi,lo}` ← product. `stall` stays 0.
- MTHI/MTLO with `act`: `hi` or `lo` ← A at the edge. The other register is unchanged.
- Divider FSM states: IDLE, BUSY, DONE. Counter `cnt` is 5 bits.
  - **IDLE**, DIV/DIVU with `act`:
    - Latch |A| and |B|. For DIVU, magnitudes are the raw values.
    - Latch sign flags: `qneg = A[31]^B[31]`, `rneg = A[31]`. Both are 0 for DIVU.
    - Latch `dz = (B==0)`.
    - Set `cnt=0` and go to BUSY. `stall=1` this cycle.
  - **BUSY**: one restoring step per cycle, 33-bit partial remainder, MSB-first quotient shift. `stall=1`. At `cnt==31`, go to DONE and write results:
    - `lo` ← qneg ? −Q : Q.
    - `hi` ← rneg ? −R : R.
    - If `dz`, HI and LO are left unchanged.
  - **DONE**: `stall=0`; the same DIV is still presented and must not restart. Unconditionally return to IDLE next edge.
- 32-bit wrap on sign fix: 0x80000000 / 0xFFFFFFFF (DIV) gives LO=0x80000000, HI=0.
- Flush in any state:
  - `stall=0` that cycle.
  - FSM goes to IDLE; partial results are discarded.
  - HI/LO are not written by the flushed op.
- Reset in any state: FSM to IDLE, `cnt=0`, `hi=lo=0`, `stall=0`.
- `ex_valid=0` or op NONE/reserved: no state change.

## Timing
- MULT/MULTU/MTHI/MTLO: write at the end of their single EX cycle. An MFHI/MFLO in the next cycle sees the new value with no forwarding needed.
- DIV/DIVU: 34 EX cycles total (1 IDLE + 32 BUSY + 1 DONE).
  - `stall` is high for cycles 0..32 and low in cycle 33.
  - HI/LO are valid from cycle 33.
- `stall` is combinational:
  - `(state==IDLE & act & op∈{DIV,DIVU}) | (state==BUSY & ~flush)`.
  - Upstream must hold `ex_op`/A/B stable while `stall=1`. Operands are latched at start anyway, so later changes are ignored.
- A divide immediately following another: the second starts in the cycle after DONE.

## Structure
- Shared package `cpu_defs`: `ex_op` encoding constants and the divider state enum (IDLE/BUSY/DONE).
- Sub-module `div_iter`: unsigned 32-step restoring divider core.
  - Ports: start, dividend, divisor, cnt-driven step; outputs Q and R.
  - Sign handling, dz, FSM, and HI/LO stay in `ex_hilo_unit`.
- Multiply is inferred (`*`) on 33-bit sign/zero-extended operands.

## Test plan
- Reset mid-divide:
  - Start DIVU, assert `resetn=0` at BUSY cycle 10.
  - Expect `hi=lo=0`, `stall=0`, FSM IDLE next cycle.
- MULT 0xFFFFFFFE × 3 → hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA. `stall` never high.
- DIV −7 / 2:
  - Expect `stall` high for exactly 33 cycles.
  - Expect lo=0xFFFFFFFD, hi=0xFFFFFFFF in cycle 33; no restart.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU x/0 with prior hi=0x11, lo=0x22 → unchanged after 34 cycles.
- Flush in BUSY cycle 5 → `stall` drops that cycle, HI/LO unchanged. A following MTLO 0x1234 gives lo=0x1234 one cycle later.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions for the EX-stage HI/LO unit.
//   - ex_op encodings for MULT/MULTU/DIV/DIVU/MTHI/MTLO
//   - divider FSM state enum
package cpu_defs;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 5;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_iter.sv
// Unsigned 32-step radix-2 restoring divider core.
// Ports:
//   clk, resetn  clock, synchronous active-low reset
//   start        load dividend/divisor, clear partial remainder
//   step         perform one restoring step this cycle
//   dividend     unsigned dividend (sampled on start)
//   divisor      unsigned divisor (sampled on start)
//   q_c, r_c     quotient/remainder after this cycle's step (combinational),
//                final values on the 32nd step
module div_iter
    import cpu_defs::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] q_c,
    output logic [XLEN-1:0] r_c
);

    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   diff;

    // One restoring step: shift in the next dividend bit MSB-first, trial subtract.
    always_comb begin
        rem_shift = {rem_q, quo_q[XLEN-1]};
        diff      = rem_shift - {1'b0, dvs_q};
        if (!diff[XLEN]) begin
            r_c = diff[XLEN-1:0];
            q_c = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            r_c = rem_shift[XLEN-1:0];
            q_c = {quo_q[XLEN-2:0], 1'b0};
        end
    end

    // Remainder never reaches the divisor, so 32 stored bits suffice.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (step) begin
            rem_q <= r_c;
            quo_q <= q_c;
        end
    end

endmodule

// File: rtl/ex_hilo_unit.sv
// EX-stage HI/LO unit: MULT/MULTU/MTHI/MTLO in one cycle, DIV/DIVU via a
// 32-step iterative divider that stalls IF/ID/EX until HI/LO are written.
// Ports:
//   clk, resetn  clock, synchronous active-low reset
//   ex_valid     EX holds a live instruction
//   ex_op        operation (see cpu_defs)
//   ex_A, ex_B   GPR[rs], GPR[rt]
//   flush        cancel the EX instruction
//   stall        combinational pipeline hold request
//   hi, lo       architectural HI/LO registers
module ex_hilo_unit
    import cpu_defs::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            ex_valid,
    input  logic [2:0]      ex_op,
    input  logic [XLEN-1:0] ex_A,
    input  logic [XLEN-1:0] ex_B,
    input  logic            flush,
    output logic            stall,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    div_state_t       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             qneg, qneg_d;
    logic             rneg, rneg_d;
    logic             dz, dz_d;
    logic [XLEN-1:0]  hi_d, lo_d;

    logic             act;
    logic             is_div;
    logic             div_signed;
    logic [XLEN-1:0]  abs_a, abs_b;
    logic             start_c, step_c;
    logic [XLEN-1:0]  q_c, r_c;

    logic signed [XLEN:0] a_ext, b_ext;
    logic [2*XLEN-1:0]    prod;

    assign act        = ex_valid & ~flush;
    assign is_div     = (ex_op == OP_DIV) | (ex_op == OP_DIVU);
    assign div_signed = (ex_op == OP_DIV);

    // Magnitudes for the unsigned core; -0x80000000 wraps to itself, which is correct.
    assign abs_a = (div_signed & ex_A[XLEN-1]) ? (XLEN'(0) - ex_A) : ex_A;
    assign abs_b = (div_signed & ex_B[XLEN-1]) ? (XLEN'(0) - ex_B) : ex_B;

    // 33-bit extension lets one signed multiplier serve both MULT and MULTU.
    assign a_ext = {(ex_op == OP_MULT) & ex_A[XLEN-1], ex_A};
    assign b_ext = {(ex_op == OP_MULT) & ex_B[XLEN-1], ex_B};
    assign prod  = 64'(a_ext) * 64'(b_ext);

    div_iter u_div_iter (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start_c),
        .step     (step_c),
        .dividend (abs_a),
        .divisor  (abs_b),
        .q_c      (q_c),
        .r_c      (r_c)
    );

    // Next-state, stall and HI/LO update logic.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        qneg_d  = qneg;
        rneg_d  = rneg;
        dz_d    = dz;
        hi_d    = hi;
        lo_d    = lo;
        start_c = 1'b0;
        step_c  = 1'b0;
        stall   = 1'b0;

        if (act) begin
            case (ex_op)
                OP_MULT, OP_MULTU: {hi_d, lo_d} = prod;
                OP_MTHI:           hi_d = ex_A;
                OP_MTLO:           lo_d = ex_A;
                default: ;
            endcase
        end

        case (state)
            IDLE: begin
                if (act && is_div) begin
                    start_c = 1'b1;
                    qneg_d  = div_signed & (ex_A[XLEN-1] ^ ex_B[XLEN-1]);
                    rneg_d  = div_signed & ex_A[XLEN-1];
                    dz_d    = (ex_B == '0);
                    cnt_d   = '0;
                    state_d = BUSY;
                    stall   = resetn;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    stall  = resetn;
                    step_c = 1'b1;
                    cnt_d  = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(XLEN - 1)) begin
                        state_d = DONE;
                        if (!dz) begin
                            lo_d = qneg ? (XLEN'(0) - q_c) : q_c;
                            hi_d = rneg ? (XLEN'(0) - r_c) : r_c;
                        end
                    end
                end
            end
            DONE: begin
                // Same DIV still presented here; leaving unconditionally prevents a restart.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and architectural register update.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
            qneg  <= 1'b0;
            rneg  <= 1'b0;
            dz    <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            qneg  <= qneg_d;
            rneg  <= rneg_d;
            dz    <= dz_d;
            hi    <= hi_d;
            lo    <= lo_d;
        end
    end

endmodule

// File: tb/tb_ex_hilo_unit.sv
// Self-checking bench for ex_hilo_unit: table of single-cycle ops plus
// hand-written divide, flush and reset sequences.
module tb_ex_hilo_unit;

    logic        clk;
    logic        resetn;
    logic        ex_valid;
    logic [2:0]  ex_op;
    logic [31:0] ex_A;
    logic [31:0] ex_B;
    logic        flush;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] NONE  = 3'd0;
    localparam logic [2:0] MULT  = 3'd1;
    localparam logic [2:0] MULTU = 3'd2;
    localparam logic [2:0] DIV   = 3'd3;
    localparam logic [2:0] DIVU  = 3'd4;
    localparam logic [2:0] MTHI  = 3'd5;
    localparam logic [2:0] MTLO  = 3'd6;
    localparam logic [2:0] RSVD  = 3'd7;

    typedef struct {
        logic        valid;
        logic        fl;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs [13];

    ex_hilo_unit dut (
        .clk      (clk),
        .resetn   (resetn),
        .ex_valid (ex_valid),
        .ex_op    (ex_op),
        .ex_A     (ex_A),
        .ex_B     (ex_B),
        .flush    (flush),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic f, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        ex_valid = v;
        flush    = f;
        ex_op    = op;
        ex_A     = a;
        ex_B     = b;
    endtask

    // Full 34-cycle divide; leaves the DIV presented after the DONE edge.
    task automatic run_div(input string name, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        n = 0;
        drive(1'b1, 1'b0, op, a, b);
        for (int c = 0; c < 34; c++) begin
            @(negedge clk);
            if (stall === 1'b1) n++;
            if (c == 33) begin
                chk({name, "_stall_done"}, 32'(stall), 32'd0);
                chk({name, "_hi"}, hi, exp_hi);
                chk({name, "_lo"}, lo, exp_lo);
            end
            tick();
        end
        chk({name, "_stall_cycles"}, 32'(n), 32'd33);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{1'b1, 1'b0, MULTU, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA};
        vecs[2]  = '{1'b1, 1'b0, MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3]  = '{1'b1, 1'b0, MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[4]  = '{1'b1, 1'b0, MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[5]  = '{1'b1, 1'b0, MULT,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[6]  = '{1'b1, 1'b0, MTHI,  32'h00000011, 32'h0000BEEF, 32'h00000011, 32'hFFFFFFEB};
        vecs[7]  = '{1'b1, 1'b0, MTLO,  32'h00000022, 32'h0000BEEF, 32'h00000011, 32'h00000022};
        vecs[8]  = '{1'b1, 1'b0, NONE,  32'hDEADBEEF, 32'h00000005, 32'h00000011, 32'h00000022};
        vecs[9]  = '{1'b1, 1'b0, RSVD,  32'hDEADBEEF, 32'h00000005, 32'h00000011, 32'h00000022};
        vecs[10] = '{1'b1, 1'b1, MULT,  32'h00000005, 32'h00000005, 32'h00000011, 32'h00000022};
        vecs[11] = '{1'b0, 1'b0, MTHI,  32'h00000099, 32'h00000000, 32'h00000011, 32'h00000022};
        vecs[12] = '{1'b1, 1'b1, DIVU,  32'h00000064, 32'h00000007, 32'h00000011, 32'h00000022};

        resetn = 1'b0;
        drive(1'b0, 1'b0, NONE, 32'h0, 32'h0);
        tick();
        tick();
        @(negedge clk);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_stall", 32'(stall), 32'd0);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].valid, vecs[i].fl, vecs[i].op, vecs[i].a, vecs[i].b);
            @(negedge clk);
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'd0);
            tick();
            chk($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
            chk($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
        end
        // Flushed DIVU in vec12 must not have left the FSM busy.
        drive(1'b0, 1'b0, NONE, 32'h0, 32'h0);
        @(negedge clk);
        chk("after_flushed_div_stall", 32'(stall), 32'd0);
        tick();

        run_div("divu_by_zero", DIVU, 32'h12345678, 32'h00000000, 32'h00000011, 32'h00000022);
        drive(1'b0, 1'b0, NONE, 32'h0, 32'h0);
        @(negedge clk);
        chk("divu_by_zero_no_restart", 32'(stall), 32'd0);
        tick();

        run_div("div_m7_2", DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        drive(1'b0, 1'b0, NONE, 32'h0, 32'h0);
        tick();

        run_div("div_wrap", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        // Back-to-back: second divide starts the cycle after DONE.
        run_div("divu_100_7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        run_div("div_7_m2", DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
        drive(1'b0, 1'b0, NONE, 32'h0, 32'h0);
        tick();

        // Flush in BUSY cycle 5, then MTLO.
        drive(1'b1, 1'b0, DIV, 32'd100, 32'd7);
        for (int c = 0; c < 6; c++) tick();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_stall", 32'(stall), 32'd0);
        tick();
        chk("flush_hi", hi, 32'd1);
        chk("flush_lo", lo, 32'hFFFFFFFD);
        drive(1'b1, 1'b0, MTLO, 32'h00001234, 32'h0);
        @(negedge clk);
        chk("post_flush_stall", 32'(stall), 32'd0);
        tick();
        chk("post_flush_mtlo_lo", lo, 32'h00001234);
        chk("post_flush_mtlo_hi", hi, 32'd1);

        // Reset at BUSY cycle 10 of a DIVU.
        drive(1'b1, 1'b0, DIVU, 32'd100, 32'd7);
        for (int c = 0; c < 11; c++) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        drive(1'b0, 1'b0, NONE, 32'h0, 32'h0);
        @(negedge clk);
        chk("midreset_stall", 32'(stall), 32'd0);
        chk("midreset_hi", hi, 32'h0);
        chk("midreset_lo", lo, 32'h0);
        tick();
        run_div("after_reset_divu", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        drive(1'b0, 1'b0, NONE, 32'h0, 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
